// File: rtl/mdu_issue_ctrl.sv
// E-stage issue controller for the multiply/divide unit: captures MDU-class
// instructions from D, launches them on the MDU, stalls D while an operation
// is in flight, returns HI/LO for mfhi/mflo and tracks MDU Busy with a shadow
// latency counter that raises a sticky protocol-error flag on disagreement.
module mdu_issue_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned OP_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Req,
    input  logic            d_valid,
    input  logic [OP_W-1:0] d_op,
    input  logic [31:0]     d_rs,
    input  logic [31:0]     d_rt,
    input  logic            Busy,
    input  logic [31:0]     HI,
    input  logic [31:0]     LO,
    output logic            Start,
    output logic [OP_W-1:0] MDUOp,
    output logic [31:0]     Data1,
    output logic [31:0]     Data2,
    output logic            Stall,
    output logic [31:0]     RdData,
    output logic            RdValid,
    output logic            Err
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [OP_W-1:0] OP_NONE  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_MFHI  = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MFLO  = OP_W'(6);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [OP_W-1:0]  e_op_q, e_op_d;
    logic [31:0]      e_a_q, e_a_d;
    logic [31:0]      e_b_q, e_b_d;
    logic             err_q, err_d;
    logic             run_prev_q;

    logic e_div_c;
    logic e_md_c;
    logic run_c;
    logic start_c;
    logic stall_c;
    logic rd_valid_c;

    // Decode of the op currently sitting in E
    assign e_div_c    = (e_op_q == OP_DIV) || (e_op_q == OP_DIVU);
    assign e_md_c     = (e_op_q == OP_MULT) || (e_op_q == OP_MULTU) || e_div_c;
    assign run_c      = (state_q == S_RUN);
    assign start_c    = e_md_c & ~Req & ~run_c;
    assign stall_c    = d_valid & (d_op != OP_NONE) & (run_c | e_md_c);
    assign rd_valid_c = ((e_op_q == OP_MFHI) || (e_op_q == OP_MFLO)) & ~Req;

    assign Start   = start_c;
    assign MDUOp   = e_op_q;
    assign Data1   = e_a_q;
    assign Data2   = e_b_q;
    assign Stall   = stall_c;
    assign RdValid = rd_valid_c;
    assign RdData  = rd_valid_c ? ((e_op_q == OP_MFHI) ? HI : LO) : 32'd0;
    assign Err     = err_q;

    // E register: bubble on flush or stall, operands hold so the MDU sees stable data
    always_comb begin
        e_op_d = OP_NONE;
        e_a_d  = e_a_q;
        e_b_d  = e_b_q;
        if (!Req && !stall_c) begin
            e_op_d = d_valid ? d_op : OP_NONE;
            e_a_d  = d_rs;
            e_b_d  = d_rt;
        end
    end

    // Shadow latency FSM; a flush freezes the count exactly as the MDU freezes
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start_c) begin
                    state_d = S_RUN;
                    cnt_d   = e_div_c ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            S_RUN: begin
                if (!Req) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Sticky protocol error: Busy disagreeing with the shadow window, or an op issued into RUN
    always_comb begin
        err_d = err_q;
        if (run_c && !Busy && run_prev_q) begin
            err_d = 1'b1;
        end
        if (!run_c && Busy && !run_prev_q) begin
            err_d = 1'b1;
        end
        if (run_c && e_md_c) begin
            err_d = 1'b1;
        end
    end

    // State and pipeline registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            e_op_q     <= OP_NONE;
            e_a_q      <= '0;
            e_b_q      <= '0;
            err_q      <= 1'b0;
            run_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            e_op_q     <= e_op_d;
            e_a_q      <= e_a_d;
            e_b_q      <= e_b_d;
            err_q      <= err_d;
            run_prev_q <= run_c;
        end
    end

endmodule
